// File: rtl/qoi_seq.sv
// Sequencer that feeds a QOI encoder's byte-wide register port from a pixel stream and
// drains its encoded bytes to a byte stream, replacing CPU polling of the encoder.
module qoi_seq #(
    parameter int SIZE_W     = 30,
    parameter int POLL_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [SIZE_W-1:0] cfg_pixels,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              px_valid,
    output logic              px_ready,
    input  logic [31:0]       px_data,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [7:0]        enc_data,
    output logic              q_cs,
    output logic              q_we,
    output logic [2:0]        q_addr,
    output logic [7:0]        q_wdata,
    input  logic [7:0]        q_rdata
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_POLL  = 3'd2,
        S_LOAD  = 3'd3,
        S_DRAIN = 3'd4,
        S_HOLD  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    // Size register bytes, LSB first; the top byte only carries six size bits.
    function automatic logic [7:0] size_byte(input logic [SIZE_W-1:0] sz, input logic [2:0] idx);
        logic [31:0] w;
        w = 32'(sz);
        case (idx)
            3'd0:    size_byte = w[7:0];
            3'd1:    size_byte = w[15:8];
            3'd2:    size_byte = w[23:16];
            3'd3:    size_byte = {2'b00, w[29:24]};
            default: size_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pixel_byte(input logic [31:0] px, input logic [2:0] idx);
        case (idx)
            3'd0:    pixel_byte = px[7:0];
            3'd1:    pixel_byte = px[15:8];
            3'd2:    pixel_byte = px[23:16];
            3'd3:    pixel_byte = px[31:24];
            default: pixel_byte = 8'h00;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [2:0]        phase_r, phase_s;
    logic [SIZE_W-1:0] size_r, size_s;
    logic [SIZE_W-1:0] pix_cnt_r, pix_cnt_s;
    logic [PW-1:0]     poll_cnt_r, poll_cnt_s;
    logic [31:0]       pixel_r, pixel_s;
    logic              error_s, enc_valid_s, busy_s, done_s, accept_s;
    logic [7:0]        enc_data_s;
    logic              cs_s, we_s, px_ready_s;
    logic [2:0]        addr_s;
    logic [7:0]        wdata_s;

    // Next-state, counters and stream-side data.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        size_s      = size_r;
        pix_cnt_s   = pix_cnt_r;
        poll_cnt_s  = poll_cnt_r;
        pixel_s     = pixel_r;
        error_s     = error;
        enc_data_s  = enc_data;
        enc_valid_s = enc_valid;
        accept_s    = (state_r == S_IDLE) && !busy && cfg_start;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    size_s    = cfg_pixels;
                    pix_cnt_s = {SIZE_W{1'b0}};
                    error_s   = 1'b0;
                    phase_s   = 3'd0;
                    if (cfg_pixels == {SIZE_W{1'b0}}) begin
                        state_s = S_FIN;
                    end else begin
                        state_s = S_CFG;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CFG: begin
                if (phase_r == 3'd4) begin
                    phase_s = 3'd0;
                    state_s = S_POLL;
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end
            S_POLL: begin
                poll_cnt_s = {PW{1'b0}};
                if (q_rdata[1]) begin
                    state_s = S_DRAIN;
                end else if (q_rdata[0] && (pix_cnt_r == size_r)) begin
                    state_s = S_FIN;
                end else if (q_rdata[0]) begin
                    phase_s = 3'd0;
                    state_s = S_LOAD;
                end else if (poll_cnt_r == POLL_LAST) begin
                    error_s = 1'b1;
                    state_s = S_FIN;
                end else begin
                    poll_cnt_s = poll_cnt_r + PW'(1);
                end
            end
            S_LOAD: begin
                // Phase 0 waits for a pixel; phases 1..4 write r, g, b, a.
                if (phase_r == 3'd0) begin
                    if (px_valid) begin
                        pixel_s = px_data;
                        phase_s = 3'd1;
                    end else begin
                        phase_s = 3'd0;
                    end
                end else if (phase_r == 3'd4) begin
                    pix_cnt_s = pix_cnt_r + SIZE_W'(1);
                    phase_s   = 3'd0;
                    state_s   = S_POLL;
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end
            S_DRAIN: begin
                enc_data_s  = q_rdata;
                enc_valid_s = 1'b1;
                state_s     = S_HOLD;
            end
            S_HOLD: begin
                if (enc_ready) begin
                    enc_valid_s = 1'b0;
                    state_s     = S_POLL;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Encoder port and px_ready are decoded from the next state so they leave a flop.
    always_comb begin
        cs_s       = 1'b0;
        we_s       = 1'b0;
        addr_s     = 3'd0;
        wdata_s    = 8'h00;
        px_ready_s = 1'b0;
        case (state_s)
            S_CFG: begin
                cs_s = 1'b1;
                we_s = 1'b1;
                if (phase_s == 3'd4) begin
                    addr_s  = 3'd3;
                    wdata_s = 8'h80;
                end else begin
                    addr_s  = 3'd4 + phase_s;
                    wdata_s = size_byte(size_s, phase_s);
                end
            end
            S_POLL: begin
                cs_s   = 1'b1;
                addr_s = 3'd3;
            end
            S_LOAD: begin
                if (phase_s == 3'd0) begin
                    px_ready_s = 1'b1;
                end else begin
                    cs_s    = 1'b1;
                    we_s    = 1'b1;
                    wdata_s = pixel_byte(pixel_s, phase_s - 3'd1);
                end
            end
            S_DRAIN: cs_s = 1'b1;
            S_FIN: begin
                cs_s   = 1'b1;
                we_s   = 1'b1;
                addr_s = 3'd3;
            end
            default: begin
                cs_s = 1'b0;
            end
        endcase
        // done follows the FIN write by one cycle; busy stays up through that done cycle.
        done_s = (state_r == S_FIN);
        if (accept_s) begin
            busy_s = 1'b1;
        end else if (done) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            phase_r    <= 3'd0;
            size_r     <= {SIZE_W{1'b0}};
            pix_cnt_r  <= {SIZE_W{1'b0}};
            poll_cnt_r <= {PW{1'b0}};
            pixel_r    <= 32'h0000_0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            px_ready   <= 1'b0;
            enc_valid  <= 1'b0;
            enc_data   <= 8'h00;
            q_cs       <= 1'b0;
            q_we       <= 1'b0;
            q_addr     <= 3'd0;
            q_wdata    <= 8'h00;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            size_r     <= size_s;
            pix_cnt_r  <= pix_cnt_s;
            poll_cnt_r <= poll_cnt_s;
            pixel_r    <= pixel_s;
            busy       <= busy_s;
            done       <= done_s;
            error      <= error_s;
            px_ready   <= px_ready_s;
            enc_valid  <= enc_valid_s;
            enc_data   <= enc_data_s;
            q_cs       <= cs_s;
            q_we       <= we_s;
            q_addr     <= addr_s;
            q_wdata    <= wdata_s;
        end
    end

endmodule
